// File: rtl/insn_mem_pipe.sv
// Instruction memory with a LATENCY-deep read pipeline, optional dual-word
// fetch, fault tagging for misaligned/out-of-range pcs and a program-load port.
module insn_mem_pipe #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned PC_W    = 32,
   parameter int unsigned LATENCY = 1,
   parameter int unsigned FETCH_N = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rd_insn_en,
   input  logic [PC_W-1:0]             pc,
   input  logic                        stall,
   input  logic                        wr_en,
   input  logic [$clog2(DEPTH)-1:0]    wr_addr,
   input  logic [DATA_W-1:0]           wr_data,
   output logic [FETCH_N*DATA_W-1:0]   insn,
   output logic                        insn_valid,
   output logic [PC_W-1:0]             insn_pc,
   output logic                        insn_fault
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned OUT_W = FETCH_N * DATA_W;

   // Elaboration-time parameter legality
   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("insn_mem_pipe: LATENCY must be 1..4");
   end
   if (FETCH_N < 1 || FETCH_N > 2) begin : g_bad_fetch_n
      $error("insn_mem_pipe: FETCH_N must be 1 or 2");
   end
   if (DEPTH < 16 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("insn_mem_pipe: DEPTH must be a power of two in 16..65536");
   end
   if (PC_W < AW + 2 || PC_W > 66) begin : g_bad_pc_w
      $error("insn_mem_pipe: PC_W too small for DEPTH");
   end

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [AW-1:0]     rd_idx;
   logic [63:0]       word_addr;
   logic              req_fault;
   logic [OUT_W-1:0]  rd_data;

   logic [LATENCY-1:0] vld_q,   vld_d;
   logic [LATENCY-1:0] fault_q, fault_d;
   logic [PC_W-1:0]    pc_q   [LATENCY];
   logic [PC_W-1:0]    pc_d   [LATENCY];
   logic [OUT_W-1:0]   data_q [LATENCY];
   logic [OUT_W-1:0]   data_d [LATENCY];

   // Program-load write port; array is deliberately not reset and ignores stall
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Decode the request and read the array; reads see pre-write contents
   always_comb begin
      rd_idx    = pc[2 +: AW];
      word_addr = 64'(pc[PC_W-1:2]);
      req_fault = (pc[1:0] != 2'b00) || (word_addr >= 64'(DEPTH));
      rd_data   = '0;
      for (int l = 0; l < int'(FETCH_N); l++) begin
         rd_data[l*DATA_W +: DATA_W] = mem_q[AW'(rd_idx + AW'(l))];
      end
      if (req_fault) begin
         rd_data = '0;
      end
   end

   // Stage advance: payload moves only with a valid token so bubbles leave
   // the output fields holding their last values; stall freezes everything
   always_comb begin
      vld_d   = vld_q;
      fault_d = fault_q;
      pc_d    = pc_q;
      data_d  = data_q;
      if (!stall) begin
         vld_d[0] = rd_insn_en;
         if (rd_insn_en) begin
            fault_d[0] = req_fault;
            pc_d[0]    = pc;
            data_d[0]  = rd_data;
         end
         for (int s = 1; s < int'(LATENCY); s++) begin
            vld_d[s] = vld_q[s-1];
            if (vld_q[s-1]) begin
               fault_d[s] = fault_q[s-1];
               pc_d[s]    = pc_q[s-1];
               data_d[s]  = data_q[s-1];
            end
         end
      end
   end

   // Pipeline registers; reset clears tokens and payload and overrides stall
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q   <= '0;
         fault_q <= '0;
         for (int s = 0; s < int'(LATENCY); s++) begin
            pc_q[s]   <= '0;
            data_q[s] <= '0;
         end
      end else begin
         vld_q   <= vld_d;
         fault_q <= fault_d;
         pc_q    <= pc_d;
         data_q  <= data_d;
      end
   end

   assign insn       = data_q[LATENCY-1];
   assign insn_valid = vld_q[LATENCY-1];
   assign insn_pc    = pc_q[LATENCY-1];
   assign insn_fault = fault_q[LATENCY-1];

endmodule

// File: tb/tb_insn_mem_pipe.sv
// Directed bench: one instance per configuration, all sharing one stimulus stream.
module tb_insn_mem_pipe;

   logic        clk = 1'b0;
   logic        rst, rd_insn_en, stall, wr_en;
   logic [31:0] pc;
   logic [9:0]  wr_addr;
   logic [31:0] wr_data;

   logic [31:0] insn1, insn_pc1, insn2, insn_pc2, insn_pc3;
   logic [63:0] insn3;
   logic        insn_valid1, insn_fault1, insn_valid2, insn_fault2, insn_valid3, insn_fault3;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Reference configuration: LATENCY=1, FETCH_N=1
   insn_mem_pipe u1 (
      .clk(clk), .rst(rst), .rd_insn_en(rd_insn_en), .pc(pc), .stall(stall),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .insn(insn1), .insn_valid(insn_valid1), .insn_pc(insn_pc1), .insn_fault(insn_fault1));

   // Deep pipeline with dual-word fetch
   insn_mem_pipe #(.LATENCY(3), .FETCH_N(2)) u3 (
      .clk(clk), .rst(rst), .rd_insn_en(rd_insn_en), .pc(pc), .stall(stall),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .insn(insn3), .insn_valid(insn_valid3), .insn_pc(insn_pc3), .insn_fault(insn_fault3));

   // Two-stage pipeline for the reset-flush sequence
   insn_mem_pipe #(.LATENCY(2)) u2 (
      .clk(clk), .rst(rst), .rd_insn_en(rd_insn_en), .pc(pc), .stall(stall),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .insn(insn2), .insn_valid(insn_valid2), .insn_pc(insn_pc2), .insn_fault(insn_fault2));

   typedef struct {
      logic        rd;
      logic [31:0] pc;
      logic        st;
      logic        we;
      logic [9:0]  wa;
      logic [31:0] wd;
      logic        ev;
      logic [31:0] ei;
      logic [31:0] ep;
      logic        ef;
   } vec_t;

   vec_t tbl [14];

   function automatic logic [31:0] wval(int i);
      case (i)
         3:       return 32'h0050_0093;
         5:       return 32'h0000_0055;
         default: return 32'h1000_0000 + 32'(i);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string nm, logic av, logic [63:0] ad, logic [31:0] ap, logic af,
                      logic ev, logic [63:0] ed, logic [31:0] ep, logic ef);
      n_vec++;
      if (av !== ev || ad !== ed || ap !== ep || af !== ef) begin
         n_err++;
         $display("FAIL %s: got valid=%0b insn=%h pc=%h fault=%0b, want valid=%0b insn=%h pc=%h fault=%0b",
                  nm, av, ad, ap, af, ev, ed, ep, ef);
      end
   endtask

   task automatic chk_vld(string nm, logic av, logic ev);
      n_vec++;
      if (av !== ev) begin
         n_err++;
         $display("FAIL %s: got valid=%0b, want %0b", nm, av, ev);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{1'b1, 32'h0000_000C, 1'b0, 1'b0, 10'd0, 32'h0,         1'b1, 32'h0050_0093, 32'h0000_000C, 1'b0};
      tbl[1]  = '{1'b1, 32'h0000_0006, 1'b0, 1'b0, 10'd0, 32'h0,         1'b1, 32'h0,         32'h0000_0006, 1'b1};
      tbl[2]  = '{1'b1, 32'h0000_1000, 1'b0, 1'b0, 10'd0, 32'h0,         1'b1, 32'h0,         32'h0000_1000, 1'b1};
      tbl[3]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 10'd0, 32'h0,         1'b0, 32'h0,         32'h0000_1000, 1'b1};
      tbl[4]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'd0, 32'h0,         1'b1, 32'h1000_0000, 32'h0000_0000, 1'b0};
      tbl[5]  = '{1'b1, 32'h0000_0004, 1'b1, 1'b0, 10'd0, 32'h0,         1'b1, 32'h1000_0000, 32'h0000_0000, 1'b0};
      tbl[6]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b0, 10'd0, 32'h0,         1'b1, 32'h1000_0001, 32'h0000_0004, 1'b0};
      tbl[7]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 10'd0, 32'h0,         1'b0, 32'h1000_0001, 32'h0000_0004, 1'b0};
      tbl[8]  = '{1'b1, 32'h0000_0014, 1'b0, 1'b1, 10'd5, 32'hDEAD_BEEF, 1'b1, 32'h0000_0055, 32'h0000_0014, 1'b0};
      tbl[9]  = '{1'b1, 32'h0000_0014, 1'b0, 1'b0, 10'd0, 32'h0,         1'b1, 32'hDEAD_BEEF, 32'h0000_0014, 1'b0};
      tbl[10] = '{1'b1, 32'h0000_0FFC, 1'b0, 1'b0, 10'd0, 32'h0,         1'b1, 32'hCAFE_F00D, 32'h0000_0FFC, 1'b0};
      tbl[11] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 10'd6, 32'h6666_6666, 1'b1, 32'hCAFE_F00D, 32'h0000_0FFC, 1'b0};
      tbl[12] = '{1'b1, 32'h0000_0018, 1'b0, 1'b0, 10'd0, 32'h0,         1'b1, 32'h6666_6666, 32'h0000_0018, 1'b0};
      tbl[13] = '{1'b1, 32'h0000_001C, 1'b0, 1'b0, 10'd0, 32'h0,         1'b1, 32'h1000_0007, 32'h0000_001C, 1'b0};

      rst = 1'b1; rd_insn_en = 1'b0; stall = 1'b0; wr_en = 1'b0;
      pc = '0; wr_addr = '0; wr_data = '0;
      tick(); tick();
      chk("reset_u1", insn_valid1, 64'(insn1), insn_pc1, insn_fault1, 1'b0, 64'h0, 32'h0, 1'b0);
      chk("reset_u3", insn_valid3, insn3,      insn_pc3, insn_fault3, 1'b0, 64'h0, 32'h0, 1'b0);
      chk("reset_u2", insn_valid2, 64'(insn2), insn_pc2, insn_fault2, 1'b0, 64'h0, 32'h0, 1'b0);
      rst = 1'b0;

      // Program load
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_addr = 10'(i); wr_data = wval(i);
         tick();
      end
      wr_addr = 10'd1023; wr_data = 32'hCAFE_F00D;
      tick();
      wr_en = 1'b0;
      tick();

      // Single-cycle configuration vectors
      for (int v = 0; v < 14; v++) begin
         rd_insn_en = tbl[v].rd; pc = tbl[v].pc; stall = tbl[v].st;
         wr_en = tbl[v].we; wr_addr = tbl[v].wa; wr_data = tbl[v].wd;
         tick();
         chk($sformatf("vec%0d", v), insn_valid1, 64'(insn1), insn_pc1, insn_fault1,
             tbl[v].ev, 64'(tbl[v].ei), tbl[v].ep, tbl[v].ef);
      end
      rd_insn_en = 1'b0; stall = 1'b0; wr_en = 1'b0;
      repeat (4) tick();

      // LATENCY=3 back-to-back fetch with a one-cycle stall on the output
      rd_insn_en = 1'b1; pc = 32'h0; tick();
      chk_vld("l3_c1", insn_valid3, 1'b0);
      pc = 32'h4; tick();
      chk_vld("l3_c2", insn_valid3, 1'b0);
      pc = 32'h8; tick();
      chk("l3_c3", insn_valid3, insn3, insn_pc3, insn_fault3, 1'b1, 64'h1000_0001_1000_0000, 32'h0, 1'b0);
      rd_insn_en = 1'b0; tick();
      chk("l3_c4", insn_valid3, insn3, insn_pc3, insn_fault3, 1'b1, 64'h1000_0002_1000_0001, 32'h4, 1'b0);
      stall = 1'b1; tick();
      chk("l3_stall", insn_valid3, insn3, insn_pc3, insn_fault3, 1'b1, 64'h1000_0002_1000_0001, 32'h4, 1'b0);
      stall = 1'b0; tick();
      chk("l3_c6", insn_valid3, insn3, insn_pc3, insn_fault3, 1'b1, 64'h0050_0093_1000_0002, 32'h8, 1'b0);
      tick();
      chk("l3_bubble", insn_valid3, insn3, insn_pc3, insn_fault3, 1'b0, 64'h0050_0093_1000_0002, 32'h8, 1'b0);

      // Dual-word wrap at the top of memory, then out-of-range
      rd_insn_en = 1'b1; pc = 32'h0000_0FFC; tick();
      pc = 32'h0000_1000; tick();
      rd_insn_en = 1'b0; tick();
      chk("wrap", insn_valid3, insn3, insn_pc3, insn_fault3, 1'b1, 64'h1000_0000_CAFE_F00D, 32'hFFC, 1'b0);
      tick();
      chk("oor_n2", insn_valid3, insn3, insn_pc3, insn_fault3, 1'b1, 64'h0, 32'h1000, 1'b1);
      tick();
      chk("oor_hold", insn_valid3, insn3, insn_pc3, insn_fault3, 1'b0, 64'h0, 32'h1000, 1'b1);

      // LATENCY=2 reset with requests in flight; reset also overrides stall
      rd_insn_en = 1'b1; pc = 32'h0; tick();
      pc = 32'h4; tick();
      chk("l2_first", insn_valid2, 64'(insn2), insn_pc2, insn_fault2, 1'b1, 64'h1000_0000, 32'h0, 1'b0);
      pc = 32'h8; rst = 1'b1; stall = 1'b1; tick();
      chk("l2_rst", insn_valid2, 64'(insn2), insn_pc2, insn_fault2, 1'b0, 64'h0, 32'h0, 1'b0);
      chk("l1_rst", insn_valid1, 64'(insn1), insn_pc1, insn_fault1, 1'b0, 64'h0, 32'h0, 1'b0);
      chk("l3_rst", insn_valid3, insn3,      insn_pc3, insn_fault3, 1'b0, 64'h0, 32'h0, 1'b0);
      rst = 1'b0; stall = 1'b0; rd_insn_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_vld($sformatf("l2_flush%0d", k), insn_valid2, 1'b0);
      end
      rd_insn_en = 1'b1; pc = 32'h4; tick();
      rd_insn_en = 1'b0; tick();
      chk("l2_after_rst", insn_valid2, 64'(insn2), insn_pc2, insn_fault2, 1'b1, 64'h1000_0001, 32'h4, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
